// File: rtl/uart_prog_loader.sv
// UART program-memory loader: receives 8N1 bytes, pairs them low-byte-first into 16-bit words
// and writes them to consecutive word addresses from 0. Optional echo transmitter: PROG_ECHO_EN.
module uart_prog_loader #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        prog_en,
    output logic [15:0] DOUT,
    output logic [15:0] PADD,
    output logic        wren,
    output logic        clock,
    output logic        busy,
    output logic        frame_err,
    output logic        tx
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int TMO  = TIMEOUT_BITS * DIV;
    localparam int TW   = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_M1   = TW'(TMO - 1);
    localparam logic PH_LOW  = 1'b0;
    localparam logic PH_HIGH = 1'b1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_W1, WR_W2, WR_W3} wr_state_t;

    logic            rx_meta_q, rxs_q, rxs_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            phase_q, phase_d;
    logic [7:0]      lo_q, lo_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    wr_state_t       wr_state_q, wr_state_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     dout_q, dout_d;
    logic [15:0]     padd_q, padd_d;
    logic            wren_q, wren_d;
    logic            clock_q, clock_d;
    logic            busy_q, busy_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_fall_s;
    logic            byte_valid_s;
    logic            echo_busy_s;

    assign rx_fall_s = rxs_prev_q & ~rxs_q;
    assign DOUT      = dout_q;
    assign PADD      = padd_q;
    assign wren      = wren_q;
    assign clock     = clock_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

    // Receive FSM: start-bit qualification, mid-bit data sampling and stop-bit check.
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_s = 1'b0;
        frame_err_d  = 1'b0;
        if (!prog_en) begin
            rx_state_d = RX_IDLE;
            cnt_d      = CNT_ZERO;
            bit_idx_d  = 3'd0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    if (rx_fall_s) begin
                        rx_state_d = RX_START;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d = CNT_ZERO;
                        if (rxs_q) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_d   = CNT_ZERO;
                        shift_d = {rxs_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_d      = CNT_ZERO;
                        rx_state_d = RX_IDLE;
                        if (rxs_q) begin
                            byte_valid_s = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    rx_state_d = RX_IDLE;
                    cnt_d      = CNT_ZERO;
                end
            endcase
        end
    end

    // Word assembly, high-byte timeout and the three-cycle write strobe sequence.
    always_comb begin
        phase_d    = phase_q;
        lo_d       = lo_q;
        tmo_d      = tmo_q;
        wr_state_d = wr_state_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        padd_d     = padd_q;
        if (!prog_en) begin
            phase_d    = PH_LOW;
            tmo_d      = TMO_ZERO;
            wr_state_d = WR_IDLE;
            addr_d     = 16'h0000;
        end else begin
            case (wr_state_q)
                WR_IDLE: wr_state_d = WR_IDLE;
                WR_W1:   wr_state_d = WR_W2;
                WR_W2:   wr_state_d = WR_W3;
                WR_W3: begin
                    wr_state_d = WR_IDLE;
                    addr_d     = addr_q + 16'd1;
                end
                default: wr_state_d = WR_IDLE;
            endcase
            if (frame_err_d) begin
                phase_d = PH_LOW;
                tmo_d   = TMO_ZERO;
            end else if (byte_valid_s) begin
                tmo_d = TMO_ZERO;
                if (phase_q == PH_LOW) begin
                    lo_d    = shift_q;
                    phase_d = PH_HIGH;
                end else begin
                    dout_d     = {shift_q, lo_q};
                    padd_d     = addr_q;
                    wr_state_d = WR_W1;
                    phase_d    = PH_LOW;
                end
            end else if ((phase_q == PH_HIGH) && (rx_state_q == RX_IDLE)) begin
                // An orphaned low byte is dropped once the line has idled too long.
                if (tmo_q == TMO_M1) begin
                    phase_d = PH_LOW;
                    tmo_d   = TMO_ZERO;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end else begin
                tmo_d = tmo_q;
            end
        end
        wren_d  = (wr_state_d == WR_W1) || (wr_state_d == WR_W2);
        clock_d = (wr_state_d == WR_W2);
        busy_d  = (rx_state_d != RX_IDLE) || (wr_state_d != WR_IDLE) ||
                  (phase_d == PH_HIGH) || echo_busy_s;
    end

`ifdef PROG_ECHO_EN
    logic        pend_full_q, pend_full_d;
    logic [7:0]  pend_q, pend_d;
    logic        tx_act_q, tx_act_d;
    logic [8:0]  tx_shift_q, tx_shift_d;
    logic [3:0]  tx_bits_q, tx_bits_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic        tx_q, tx_d;

    assign tx = tx_q;

    // Echo transmitter fed from a single pending slot; bytes arriving while it is full are not echoed.
    always_comb begin
        pend_full_d = pend_full_q;
        pend_d      = pend_q;
        tx_act_d    = tx_act_q;
        tx_shift_d  = tx_shift_q;
        tx_bits_d   = tx_bits_q;
        tx_cnt_d    = tx_cnt_q;
        tx_d        = tx_q;
        if (!prog_en) begin
            pend_full_d = 1'b0;
            tx_act_d    = 1'b0;
            tx_bits_d   = 4'd0;
            tx_cnt_d    = CNT_ZERO;
            tx_d        = 1'b1;
        end else begin
            if (!tx_act_q) begin
                if (pend_full_q) begin
                    tx_act_d    = 1'b1;
                    tx_shift_d  = {1'b1, pend_q};
                    tx_bits_d   = 4'd0;
                    tx_cnt_d    = CNT_ZERO;
                    tx_d        = 1'b0;
                    pend_full_d = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end else if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = CNT_ZERO;
                if (tx_bits_q == 4'd9) begin
                    tx_act_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bits_d  = tx_bits_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
            if (byte_valid_s && !pend_full_q) begin
                pend_d      = shift_q;
                pend_full_d = 1'b1;
            end else begin
                pend_d = pend_d;
            end
        end
        echo_busy_s = tx_act_d || pend_full_d;
    end

    // Echo transmitter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_full_q <= 1'b0;
            pend_q      <= 8'h00;
            tx_act_q    <= 1'b0;
            tx_shift_q  <= 9'h1FF;
            tx_bits_q   <= 4'd0;
            tx_cnt_q    <= CNT_ZERO;
            tx_q        <= 1'b1;
        end else begin
            pend_full_q <= pend_full_d;
            pend_q      <= pend_d;
            tx_act_q    <= tx_act_d;
            tx_shift_q  <= tx_shift_d;
            tx_bits_q   <= tx_bits_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_q        <= tx_d;
        end
    end
`else
    assign echo_busy_s = 1'b0;
    assign tx          = 1'b1;
`endif

    // Input synchronizer plus all receive, assembly and write-sequence registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            phase_q     <= PH_LOW;
            lo_q        <= 8'h00;
            tmo_q       <= TMO_ZERO;
            wr_state_q  <= WR_IDLE;
            addr_q      <= 16'h0000;
            dout_q      <= 16'h0000;
            padd_q      <= 16'h0000;
            wren_q      <= 1'b0;
            clock_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            rxs_prev_q  <= rxs_q;
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            phase_q     <= phase_d;
            lo_q        <= lo_d;
            tmo_q       <= tmo_d;
            wr_state_q  <= wr_state_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            padd_q      <= padd_d;
            wren_q      <= wren_d;
            clock_q     <= clock_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at DIV=16: vector table of word loads plus hand-built
// sequences for framing errors, timeout, glitch rejection, address wrap, prog_en abort and echo.
module tb_uart_prog_loader;

    localparam int BIT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic        prog_en = 1'b0;
    logic [15:0] DOUT, PADD;
    logic        wren, clock, busy, frame_err, tx;

    uart_prog_loader #(.CLK_HZ(1_600_000), .BAUD(100_000), .TIMEOUT_BITS(64)) dut (
        .clk(clk), .rst(rst), .rx(rx), .prog_en(prog_en),
        .DOUT(DOUT), .PADD(PADD), .wren(wren), .clock(clock),
        .busy(busy), .frame_err(frame_err), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] exp_dout;
        logic [15:0] exp_padd;
    } vec_t;

    typedef struct {
        logic [15:0] dout;
        logic [15:0] padd;
        int          wlen;
        int          clen;
    } wr_t;

    int   n_vec = 0;
    int   n_err = 0;
    wr_t  wr_q[$];
    wr_t  cur;
    logic in_wr = 1'b0;
    int   fe_cycles = 0;
    int   tx_low_cycles = 0;
    logic cap_en = 1'b0;
    logic cap_q[$];

    // Observe write strobes, frame errors and tx on the falling edge.
    always @(negedge clk) begin
        if (wren) begin
            if (!in_wr) begin
                cur.dout = DOUT;
                cur.padd = PADD;
                cur.wlen = 0;
                cur.clen = 0;
                in_wr = 1'b1;
            end
            cur.wlen = cur.wlen + 1;
            if (clock) cur.clen = cur.clen + 1;
        end else if (in_wr) begin
            wr_q.push_back(cur);
            in_wr = 1'b0;
        end
        if (frame_err) fe_cycles = fe_cycles + 1;
        if (!tx) tx_low_cycles = tx_low_cycles + 1;
        if (cap_en) cap_q.push_back(tx);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop;
        tick(BIT);
        rx = 1'b1;
    endtask

    task automatic expect_word(input string name, input logic [15:0] d, input logic [15:0] a);
        wr_t w;
        int  waited = 0;
        while (wr_q.size() == 0 && waited < 64) begin
            tick(1);
            waited++;
        end
        if (wr_q.size() == 0) begin
            check({name, " write seen"}, 32'd0, 32'd1);
        end else begin
            w = wr_q.pop_front();
            check({name, " DOUT"}, {16'd0, w.dout}, {16'd0, d});
            check({name, " PADD"}, {16'd0, w.padd}, {16'd0, a});
            check({name, " wren cycles"}, w.wlen, 32'd2);
            check({name, " clock cycles"}, w.clen, 32'd1);
        end
    endtask

    task automatic restart_enable();
        prog_en = 1'b0;
        tick(3);
        prog_en = 1'b1;
        tick(BIT);
    endtask

    vec_t vecs[5];
    int   fe0;
    int   first0;
    logic [9:0] exp_tx;

    initial begin
        vecs[0] = '{lo: 8'h34, hi: 8'h12, exp_dout: 16'h1234, exp_padd: 16'h0000};
        vecs[1] = '{lo: 8'h78, hi: 8'h56, exp_dout: 16'h5678, exp_padd: 16'h0001};
        vecs[2] = '{lo: 8'hFF, hi: 8'h00, exp_dout: 16'h00FF, exp_padd: 16'h0002};
        vecs[3] = '{lo: 8'h00, hi: 8'hFF, exp_dout: 16'hFF00, exp_padd: 16'h0003};
        vecs[4] = '{lo: 8'hA5, hi: 8'h5A, exp_dout: 16'h5AA5, exp_padd: 16'h0004};

        tick(3);
        check("reset DOUT", {16'd0, DOUT}, 32'h0);
        check("reset PADD", {16'd0, PADD}, 32'h0);
        check("reset wren/clock/busy/ferr/tx", {27'd0, wren, clock, busy, frame_err, tx}, 32'h1);
        rst = 1'b1;
        prog_en = 1'b1;
        tick(BIT);
        check("idle busy", {31'd0, busy}, 32'h0);

        // T1: table-driven word loads.
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].lo, 1'b1);
            send_byte(vecs[i].hi, 1'b1);
            expect_word($sformatf("T1 vec%0d", i), vecs[i].exp_dout, vecs[i].exp_padd);
        end
        tick(BIT);
        check("T1 busy after load", {31'd0, busy}, 32'h0);

        // T2: a framing error drops the pending low byte.
        restart_enable();
        fe0 = fe_cycles;
        send_byte(8'h77, 1'b1);
        send_byte(8'h0F, 1'b0);
        tick(2 * BIT);
        check("T2 frame_err cycles", fe_cycles - fe0, 32'd1);
        check("T2 no write", wr_q.size(), 32'd0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        expect_word("T2", 16'h55AA, 16'h0000);

        // T3: low byte times out after 64 idle bit-times.
        restart_enable();
        send_byte(8'h11, 1'b1);
        tick(60 * BIT);
        check("T3 busy before timeout", {31'd0, busy}, 32'h1);
        tick(5 * BIT);
        check("T3 busy after timeout", {31'd0, busy}, 32'h0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        expect_word("T3", 16'h3322, 16'h0000);

        // T4: short low glitch is rejected at the start-bit sample.
        fe0 = fe_cycles;
        rx = 1'b0;
        tick(BIT / 4);
        rx = 1'b1;
        tick(2 * BIT);
        check("T4 frame_err", fe_cycles - fe0, 32'd0);
        check("T4 busy", {31'd0, busy}, 32'h0);
        check("T4 no write", wr_q.size(), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        expect_word("T4 after glitch", 16'h0201, 16'h0001);

        // T5: address wrap, then prog_en dropped inside a high byte.
        @(negedge clk);
        force dut.addr_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.addr_q;
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        expect_word("T5 wrap", 16'hABCD, 16'hFFFF);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        expect_word("T5 after wrap", 16'h0001, 16'h0000);
        send_byte(8'h99, 1'b1);
        rx = 1'b0;
        tick(BIT);
        rx = 1'b1;
        tick(2 * BIT);
        prog_en = 1'b0;
        tick(2);
        check("T5 busy abort", {30'd0, busy, wren}, 32'h0);
        tick(8 * BIT);
        check("T5 DOUT held", {16'd0, DOUT}, 32'h0001);
        prog_en = 1'b1;
        tick(BIT);
        check("T5 no write", wr_q.size(), 32'd0);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        expect_word("T5 re-enable", 16'h3344, 16'h0000);

        // T6: echo of 0xC3 (or tx constantly high without the echo build).
        cap_q.delete();
        cap_en = 1'b1;
        send_byte(8'hC3, 1'b1);
        tick(11 * BIT);
        cap_en = 1'b0;
`ifdef PROG_ECHO_EN
        first0 = -1;
        for (int i = 0; i < cap_q.size(); i++) begin
            if (first0 < 0 && cap_q[i] == 1'b0) first0 = i;
        end
        check("T6 echo start seen", {31'd0, first0 >= 0}, 32'h1);
        exp_tx = 10'b11_1100_0011_0 ;
        if (first0 >= 0) begin
            for (int k = 0; k < 10; k++) begin
                if (first0 + 8 + BIT * k < cap_q.size())
                    check($sformatf("T6 tx bit%0d", k), {31'd0, cap_q[first0 + 8 + BIT * k]},
                          {31'd0, exp_tx[k]});
                else
                    check($sformatf("T6 tx bit%0d captured", k), 32'd0, 32'd1);
            end
        end
`else
        first0 = tx_low_cycles;
        check("T6 tx stays high", first0, 32'd0);
`endif
        send_byte(8'h3C, 1'b1);
        expect_word("T6 word", 16'h3CC3, 16'h0001);
        tick(12 * BIT);
        check("final busy", {31'd0, busy}, 32'h0);
        check("no stray writes", wr_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
